branch_predictor: RTL and testbench

Dynamic branch predictor and resolution unit for the five-stage pipeline. Looks up the fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters and drives `IF_expectedTaken`/`IF_predTarget` into fetch and the IF/ID latch. Takes resolved branch outcomes back from EX, trains the table and raises `NOP_Branch` plus a redirect PC on a mispredict, which squashes the wrong-path instructions.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/bp_sat_ctr2.sv | 20 ++
 rtl/register.sv | 19 +
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and encodings for the branch predictor.
// Counter states, default geometry and the table entry layout.
package bp_pkg;

  localparam int DEF_INDEX_BITS = 4;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Tag kept full-width; upper bits are zero for any index size.
  typedef struct packed {
    logic        valid;
    logic [15:0] tag;
    logic [15:0] target;
    logic [1:0]  ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating counter next-state function.
// Moves one step toward the resolved direction.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/register.sv
// Enabled register with asynchronous active-high reset.
// Used as the storage primitive for every table entry.
module register #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, EX-side training
// and combinational mispredict/redirect generation.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         INDEX_BITS = DEF_INDEX_BITS,
  parameter logic [1:0] CTR_INIT   = WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IF_PC,
  output logic        IF_expectedTaken,
  output logic [15:0] IF_predTarget,
  input  logic        EX_valid,
  input  logic [15:0] EX_PC,
  input  logic        EX_taken,
  input  logic [15:0] EX_target,
  input  logic        EX_expectedTaken,
  input  logic [15:0] EX_predTarget,
  output logic        NOP_Branch,
  output logic [15:0] redirect_PC,
  output logic [15:0] mispredict_count
);

  localparam int N = 1 << INDEX_BITS;

  localparam bp_entry_t RST_ENTRY = '{
    valid:  1'b0,
    tag:    16'h0,
    target: 16'h0,
    ctr:    CTR_INIT
  };

  bp_entry_t tbl_q [N];

  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [15:0]           if_tag;
  logic [15:0]           ex_tag;
  bp_entry_t             if_e;
  bp_entry_t             ex_e;
  logic                  if_hit;
  logic                  ex_hit;
  logic [1:0]            ctr_nxt;
  logic                  upd_en;
  bp_entry_t             upd_d;
  logic [15:0]           cnt_q;
  logic [15:0]           cnt_d;

  assign if_idx = IF_PC[INDEX_BITS:1];
  assign ex_idx = EX_PC[INDEX_BITS:1];
  assign if_tag = IF_PC >> (INDEX_BITS + 1);
  assign ex_tag = EX_PC >> (INDEX_BITS + 1);

  assign if_e   = tbl_q[if_idx];
  assign ex_e   = tbl_q[ex_idx];
  assign if_hit = if_e.valid && (if_e.tag == if_tag);
  assign ex_hit = ex_e.valid && (ex_e.tag == ex_tag);

  assign IF_expectedTaken = if_hit & if_e.ctr[1];
  assign IF_predTarget    = IF_expectedTaken ? if_e.target
                                             : IF_PC + 16'd2;

  assign NOP_Branch = EX_valid &
    ((EX_taken != EX_expectedTaken) |
     (EX_taken & EX_expectedTaken & (EX_target != EX_predTarget)));
  assign redirect_PC = EX_taken ? EX_target : EX_PC + 16'd2;

  bp_sat_ctr2 u_ctr (
    .ctr_i   (ex_e.ctr),
    .taken_i (EX_taken),
    .ctr_o   (ctr_nxt)
  );

  // A not-taken miss would only pollute the table, so it is dropped.
  always_comb begin
    upd_en = EX_valid & (ex_hit | EX_taken);
    upd_d  = ex_e;
    if (ex_hit) begin
      upd_d.ctr = ctr_nxt;
      if (EX_taken) upd_d.target = EX_target;
    end else begin
      upd_d.valid  = 1'b1;
      upd_d.tag    = ex_tag;
      upd_d.target = EX_target;
      upd_d.ctr    = WT;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_tbl
    register #(
      .W       ($bits(bp_entry_t)),
      .RST_VAL (RST_ENTRY)
    ) u_ent (
      .clk  (clk),
      .rst  (rst),
      .en_i (upd_en && (ex_idx == INDEX_BITS'(i))),
      .d_i  (upd_d),
      .q_o  (tbl_q[i])
    );
  end

  assign cnt_d = (NOP_Branch && cnt_q != 16'hFFFF) ? cnt_q + 16'd1
                                                   : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 16'h0;
    else     cnt_q <= cnt_d;
  end

  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Inputs change after negedge; outputs sampled mid-cycle.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IF_PC;
  logic        IF_expectedTaken;
  logic [15:0] IF_predTarget;
  logic        EX_valid;
  logic [15:0] EX_PC;
  logic        EX_taken;
  logic [15:0] EX_target;
  logic        EX_expectedTaken;
  logic [15:0] EX_predTarget;
  logic        NOP_Branch;
  logic [15:0] redirect_PC;
  logic [15:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .IF_PC            (IF_PC),
    .IF_expectedTaken (IF_expectedTaken),
    .IF_predTarget    (IF_predTarget),
    .EX_valid         (EX_valid),
    .EX_PC            (EX_PC),
    .EX_taken         (EX_taken),
    .EX_target        (EX_target),
    .EX_expectedTaken (EX_expectedTaken),
    .EX_predTarget    (EX_predTarget),
    .NOP_Branch       (NOP_Branch),
    .redirect_PC      (redirect_PC),
    .mispredict_count (mispredict_count)
  );

  task automatic ex_set(input logic v, input logic [15:0] pc,
                        input logic tk, input logic [15:0] tg,
                        input logic et, input logic [15:0] pt);
    EX_valid = v; EX_PC = pc; EX_taken = tk;
    EX_target = tg; EX_expectedTaken = et; EX_predTarget = pt;
  endtask

  // Apply inputs after a negedge, then settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    IF_PC = 16'h0010;
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b0) begin
      errors++;
      $display("FAIL reset_taken got %b want 0", IF_expectedTaken);
    end
    checks++;
    if (IF_predTarget !== 16'h0012) begin
      errors++;
      $display("FAIL reset_target got %h want 0012", IF_predTarget);
    end
    checks++;
    if (mispredict_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h want 0000", mispredict_count);
    end
  endtask

  task automatic test_alloc();
    step();
    IF_PC = 16'h0010;
    ex_set(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0012);
    #1;
    checks++;
    if (NOP_Branch !== 1'b1) begin
      errors++;
      $display("FAIL alloc_nop got %b want 1", NOP_Branch);
    end
    checks++;
    if (redirect_PC !== 16'h0040) begin
      errors++;
      $display("FAIL alloc_redir got %h want 0040", redirect_PC);
    end
    checks++;
    if (IF_expectedTaken !== 1'b0) begin
      errors++;
      $display("FAIL alloc_nobypass got %b want 0", IF_expectedTaken);
    end
    step();
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b1 || IF_predTarget !== 16'h0040) begin
      errors++;
      $display("FAIL alloc_pred got %b/%h want 1/0040",
               IF_expectedTaken, IF_predTarget);
    end
    checks++;
    if (mispredict_count !== 16'd1) begin
      errors++;
      $display("FAIL alloc_cnt got %0d want 1", mispredict_count);
    end
  endtask

  task automatic test_saturate();
    IF_PC = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      ex_set(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
      #1;
      checks++;
      if (NOP_Branch !== 1'b0) begin
        errors++;
        $display("FAIL sat_nop%0d got %b want 0", i, NOP_Branch);
      end
      step();
    end
    ex_set(1'b1, 16'h0010, 1'b0, 16'h0040, 1'b1, 16'h0040);
    #1;
    checks++;
    if (NOP_Branch !== 1'b1 || redirect_PC !== 16'h0012) begin
      errors++;
      $display("FAIL nt1_redir got %b/%h want 1/0012",
               NOP_Branch, redirect_PC);
    end
    step();
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b1) begin
      errors++;
      $display("FAIL nt1_pred got %b want 1", IF_expectedTaken);
    end
    ex_set(1'b1, 16'h0010, 1'b0, 16'h0040, 1'b1, 16'h0040);
    step();
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b0 || IF_predTarget !== 16'h0012) begin
      errors++;
      $display("FAIL nt2_pred got %b/%h want 0/0012",
               IF_expectedTaken, IF_predTarget);
    end
    checks++;
    if (mispredict_count !== 16'd3) begin
      errors++;
      $display("FAIL sat_cnt got %0d want 3", mispredict_count);
    end
  endtask

  task automatic test_alias();
    ex_set(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0012);
    step();
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    IF_PC = 16'h0010;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b1) begin
      errors++;
      $display("FAIL alias_pre got %b want 1", IF_expectedTaken);
    end
    IF_PC = 16'h0030;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b0 || IF_predTarget !== 16'h0032) begin
      errors++;
      $display("FAIL alias_miss got %b/%h want 0/0032",
               IF_expectedTaken, IF_predTarget);
    end
    ex_set(1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0, 16'h0032);
    step();
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    IF_PC = 16'h0010;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b0 || IF_predTarget !== 16'h0012) begin
      errors++;
      $display("FAIL alias_evict got %b/%h want 0/0012",
               IF_expectedTaken, IF_predTarget);
    end
    IF_PC = 16'h0030;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b1 || IF_predTarget !== 16'h0100) begin
      errors++;
      $display("FAIL alias_new got %b/%h want 1/0100",
               IF_expectedTaken, IF_predTarget);
    end
    checks++;
    if (mispredict_count !== 16'd5) begin
      errors++;
      $display("FAIL alias_cnt got %0d want 5", mispredict_count);
    end
  endtask

  task automatic test_target();
    ex_set(1'b1, 16'h0020, 1'b1, 16'h0040, 1'b0, 16'h0022);
    step();
    ex_set(1'b1, 16'h0020, 1'b1, 16'h0080, 1'b1, 16'h0040);
    #1;
    checks++;
    if (NOP_Branch !== 1'b1 || redirect_PC !== 16'h0080) begin
      errors++;
      $display("FAIL tgt_redir got %b/%h want 1/0080",
               NOP_Branch, redirect_PC);
    end
    step();
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    IF_PC = 16'h0020;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b1 || IF_predTarget !== 16'h0080) begin
      errors++;
      $display("FAIL tgt_pred got %b/%h want 1/0080",
               IF_expectedTaken, IF_predTarget);
    end
    checks++;
    if (mispredict_count !== 16'd7) begin
      errors++;
      $display("FAIL tgt_cnt got %0d want 7", mispredict_count);
    end
  endtask

  task automatic test_idle();
    ex_set(1'b1, 16'h0050, 1'b0, 16'h0090, 1'b0, 16'h0052);
    #1;
    checks++;
    if (NOP_Branch !== 1'b0 || redirect_PC !== 16'h0052) begin
      errors++;
      $display("FAIL ntmiss_nop got %b/%h want 0/0052",
               NOP_Branch, redirect_PC);
    end
    step();
    ex_set(1'b0, 16'h0060, 1'b1, 16'h0090, 1'b0, 16'h0062);
    IF_PC = 16'h0050;
    #1;
    checks++;
    if (NOP_Branch !== 1'b0) begin
      errors++;
      $display("FAIL invalid_nop got %b want 0", NOP_Branch);
    end
    step();
    checks++;
    if (IF_expectedTaken !== 1'b0 || mispredict_count !== 16'd7) begin
      errors++;
      $display("FAIL idle_state got %b/%0d want 0/7",
               IF_expectedTaken, mispredict_count);
    end
    IF_PC = 16'h0060;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b0) begin
      errors++;
      $display("FAIL invalid_alloc got %b want 0", IF_expectedTaken);
    end
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_wrap();
    IF_PC = 16'hFFFE;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b0 || IF_predTarget !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_if got %b/%h want 0/0000",
               IF_expectedTaken, IF_predTarget);
    end
    ex_set(1'b1, 16'hFFFE, 1'b0, 16'h1234, 1'b1, 16'h1234);
    #1;
    checks++;
    if (NOP_Branch !== 1'b1 || redirect_PC !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_redir got %b/%h want 1/0000",
               NOP_Branch, redirect_PC);
    end
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_async_reset();
    step();
    IF_PC = 16'h0030;
    ex_set(1'b1, 16'h0020, 1'b1, 16'h0080, 1'b1, 16'h0080);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (IF_expectedTaken !== 1'b0 || IF_predTarget !== 16'h0032) begin
      errors++;
      $display("FAIL arst_pred got %b/%h want 0/0032",
               IF_expectedTaken, IF_predTarget);
    end
    checks++;
    if (mispredict_count !== 16'h0) begin
      errors++;
      $display("FAIL arst_cnt got %h want 0000", mispredict_count);
    end
    step();
    rst = 1'b0;
    ex_set(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    IF_PC = 16'h0020;
    step();
    checks++;
    if (IF_expectedTaken !== 1'b0 || IF_predTarget !== 16'h0022) begin
      errors++;
      $display("FAIL arst_after got %b/%h want 0/0022",
               IF_expectedTaken, IF_predTarget);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturate();
    test_alias();
    test_target();
    test_idle();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
